nxs_work_scheduler: RTL

NXS_WORK_SCHEDULER -- requirements
Module: nxs_work_scheduler

---
 rtl/nxs_sched_pkg.sv | 21 ++
 rtl/nxs_nonce_fifo.sv | 94 +++++++++
 rtl/nxs_work_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/nxs_sched_pkg.sv
// Shared types and widths for the work scheduler and its nonce buffer.
package nxs_sched_pkg;

   localparam int WORK_W  = 1728;
   localparam int NONCE_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } sched_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (&v) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/nxs_nonce_fifo.sv
// Found-nonce buffer: DEPTH-entry FIFO with NXS_SCHED_NONCE_FIFO_EN defined,
// otherwise a single overwrite-on-full holding register.
module nxs_nonce_fifo
   import nxs_sched_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic               clk,
   input  logic               nRst,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic               i_flush,
   input  logic [NONCE_W-1:0] i_data,
   output logic               o_full,
   output logic               o_empty,
   output logic               o_accept,
   output logic [NONCE_W-1:0] o_head
);

   generate
      if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
         $error("nxs_nonce_fifo: DEPTH must be a power of two in 2..16");
      end
   endgenerate

`ifdef NXS_SCHED_NONCE_FIFO_EN
   localparam int AW = $clog2(DEPTH);

   logic [NONCE_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW:0]        r_count;
   logic               w_pop;
   logic               w_wr;

   assign o_empty  = (r_count == '0);
   assign o_full   = (r_count == (AW+1)'(DEPTH));
   assign w_pop    = i_pop && !o_empty && !i_flush;
   // A full buffer still takes a push when the head leaves in the same cycle.
   assign w_wr     = i_push && !i_flush && (!o_full || w_pop);
   assign o_accept = w_wr;
   assign o_head   = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
      end
   end
`else
   logic [NONCE_W-1:0] r_data;
   logic               r_full;

   assign o_full   = r_full;
   assign o_empty  = !r_full;
   assign o_head   = r_data;
   assign o_accept = i_push && !i_flush;

   // A push always lands; when it hits a held entry, that entry is lost.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_data <= '0;
         r_full <= 1'b0;
      end else if (i_flush) begin
         r_full <= 1'b0;
      end else if (i_push) begin
         r_data <= i_data;
         r_full <= 1'b1;
      end else if (i_pop) begin
         r_full <= 1'b0;
      end
   end
`endif

endmodule

// File: rtl/nxs_work_scheduler.sv
// Loads work into the hash core through a timed reset window and buffers found
// nonces for the transmitter. Buffer depth selected by NXS_SCHED_NONCE_FIFO_EN.
module nxs_work_scheduler
   import nxs_sched_pkg::*;
#(
   parameter int RST_CYCLES = 4,
   parameter int FIFO_DEPTH = 4
)(
   input  logic               clk,
   input  logic               nRst,
   input  logic               work_valid,
   input  logic [WORK_W-1:0]  work_data,
   input  logic               core_found,
   input  logic [NONCE_W-1:0] core_nonce,
   input  logic               tx_ready,
   output logic               core_nRst,
   output logic [WORK_W-1:0]  core_work,
   output logic               tx_valid,
   output logic [NONCE_W-1:0] tx_nonce,
   output logic [1:0]         sched_state,
   output logic [15:0]        found_cnt,
   output logic [7:0]         drop_cnt
);

   generate
      if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_rst_cycles_check
         $error("nxs_work_scheduler: RST_CYCLES must be in 1..255");
      end
   endgenerate

   sched_state_t       r_state;
   sched_state_t       w_state_next;
   logic [7:0]         r_load_cnt;
   logic [7:0]         w_load_cnt_next;
   logic [WORK_W-1:0]  r_core_work;
   logic [15:0]        r_found_cnt;
   logic [7:0]         r_drop_cnt;

   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic               w_accept;
   logic               w_drop;
   logic [NONCE_W-1:0] w_head;

   always_comb begin
      w_state_next    = r_state;
      w_load_cnt_next = r_load_cnt;
      if (work_valid) begin
         w_state_next    = ST_LOAD;
         w_load_cnt_next = 8'(RST_CYCLES);
      end else begin
         case (r_state)
            ST_IDLE: w_state_next = ST_IDLE;
            ST_LOAD: begin
               if (r_load_cnt <= 8'd1) begin
                  w_state_next = ST_RUN;
               end else begin
                  w_load_cnt_next = r_load_cnt - 8'd1;
               end
            end
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state     <= ST_IDLE;
         r_load_cnt  <= '0;
         r_core_work <= '0;
         r_found_cnt <= '0;
         r_drop_cnt  <= '0;
      end else begin
         r_state    <= w_state_next;
         r_load_cnt <= w_load_cnt_next;
         // New work invalidates every nonce found for the previous one.
         if (work_valid) begin
            r_core_work <= work_data;
            r_found_cnt <= '0;
            r_drop_cnt  <= '0;
         end else begin
            if (w_accept) begin
               r_found_cnt <= sat_inc16(r_found_cnt);
            end
            if (w_drop) begin
               r_drop_cnt <= sat_inc8(r_drop_cnt);
            end
         end
      end
   end

   assign w_push = core_found && (r_state == ST_RUN) && !work_valid;
   assign w_pop  = tx_valid && tx_ready;
   assign w_drop = w_push && w_full && !w_pop;

   nxs_nonce_fifo #(
      .DEPTH    (FIFO_DEPTH)
   ) u_nonce_fifo (
      .clk      (clk),
      .nRst     (nRst),
      .i_push   (w_push),
      .i_pop    (w_pop),
      .i_flush  (work_valid),
      .i_data   (core_nonce),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_accept (w_accept),
      .o_head   (w_head)
   );

   assign core_nRst   = (r_state == ST_RUN);
   assign core_work   = r_core_work;
   assign tx_valid    = !w_empty;
   assign tx_nonce    = w_empty ? '0 : w_head;
   assign sched_state = r_state;
   assign found_cnt   = r_found_cnt;
   assign drop_cnt    = r_drop_cnt;

endmodule
